// File: rtl/sa_pe_mw_pkg.sv
// Shared types and arithmetic helpers for the multi-weight systolic PE.
package sa_pkg;

  typedef enum logic {
    SA_PRELOAD = 1'b0,
    SA_COMPUTE = 1'b1
  } sa_mode_e;

  // Widest psum the saturating adder supports.
  localparam int SA_MAX_W = 64;

  typedef struct packed {
    logic signed [SA_MAX_W-1:0] sum;
    logic                       ovf;
  } sat_res_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Adds two sign-extended operands one bit wider than SA_MAX_W, then clamps to a signed range of 'width' bits.
  function automatic sat_res_t sat_add(input logic signed [SA_MAX_W-1:0] a,
                                       input logic signed [SA_MAX_W-1:0] b,
                                       input int unsigned width);
    logic signed [SA_MAX_W:0] s;
    logic signed [SA_MAX_W:0] one;
    logic signed [SA_MAX_W:0] hi;
    logic signed [SA_MAX_W:0] lo;
    sat_res_t r;
    one    = '0;
    one[0] = 1'b1;
    s      = {a[SA_MAX_W-1], a} + {b[SA_MAX_W-1], b};
    hi     = (one << (width - 1)) - one;
    lo     = ~hi;
    r.ovf  = (s > hi) || (s < lo);
    if (s > hi)
      r.sum = hi[SA_MAX_W-1:0];
    else if (s < lo)
      r.sum = lo[SA_MAX_W-1:0];
    else
      r.sum = s[SA_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sa_pe_mw_if.sv
// Stream bundle around one PE: weight column, activation row, psum column and overflow flag.
interface sa_pe_mw_if
  import sa_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32,
  parameter int WEIGHT_DEPTH  = 4
);
  localparam int IDX_W = idx_width(WEIGHT_DEPTH);

  logic                            i_mode;
  logic                            i_weight_valid;
  logic signed [MUL_DATAWIDTH-1:0] i_weight;
  logic        [IDX_W-1:0]         i_weight_idx;
  logic                            o_weight_valid;
  logic signed [MUL_DATAWIDTH-1:0] o_weight;
  logic        [IDX_W-1:0]         o_weight_idx;
  logic                            i_act_valid;
  logic signed [MUL_DATAWIDTH-1:0] i_act;
  logic        [IDX_W-1:0]         i_wsel;
  logic                            o_act_valid;
  logic signed [MUL_DATAWIDTH-1:0] o_act;
  logic        [IDX_W-1:0]         o_wsel;
  logic signed [ADD_DATAWIDTH-1:0] i_psum;
  logic                            o_psum_valid;
  logic signed [ADD_DATAWIDTH-1:0] o_psum;
  logic                            i_clr_ovf;
  logic                            o_ovf;

  modport slave (
    input  i_mode, i_weight_valid, i_weight, i_weight_idx,
    input  i_act_valid, i_act, i_wsel, i_psum, i_clr_ovf,
    output o_weight_valid, o_weight, o_weight_idx,
    output o_act_valid, o_act, o_wsel, o_psum_valid, o_psum, o_ovf
  );

  modport master (
    output i_mode, i_weight_valid, i_weight, i_weight_idx,
    output i_act_valid, i_act, i_wsel, i_psum, i_clr_ovf,
    input  o_weight_valid, o_weight, o_weight_idx,
    input  o_act_valid, o_act, o_wsel, o_psum_valid, o_psum, o_ovf
  );
endinterface

// File: rtl/sa_mac_sat.sv
// Combinational signed MAC: psum + act*weight with optional saturation and an overflow indication.
module sa_mac_sat
  import sa_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32,
  parameter int SATURATE      = 1
) (
  input  logic signed [MUL_DATAWIDTH-1:0] i_act,
  input  logic signed [MUL_DATAWIDTH-1:0] i_weight,
  input  logic signed [ADD_DATAWIDTH-1:0] i_psum,
  output logic signed [ADD_DATAWIDTH-1:0] o_psum,
  output logic                            o_ovf
);
  logic signed [2*MUL_DATAWIDTH-1:0] prod;
  sat_res_t                          res;
  logic                              unused_sum;

  assign prod       = i_act * i_weight;
  assign res        = sat_add(SA_MAX_W'(i_psum), SA_MAX_W'(prod), ADD_DATAWIDTH);
  assign o_ovf      = res.ovf;
  assign unused_sum = ^res.sum;

  generate
    if (SATURATE != 0) begin : g_sat
      assign o_psum = res.sum[ADD_DATAWIDTH-1:0];
    end else begin : g_wrap
      assign o_psum = i_psum + ADD_DATAWIDTH'(prod);
    end
  endgenerate
endmodule

// File: rtl/sa_pe_mw.sv
// Weight-stationary systolic PE holding a small bank of weights selected per activation.
module sa_pe_mw
  import sa_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32,
  parameter int WEIGHT_DEPTH  = 4,
  parameter int SATURATE      = 1
) (
  input logic  clk,
  input logic  rst_n,
  sa_pe_mw_if.slave bus
);
  localparam int IDX_W = idx_width(WEIGHT_DEPTH);

  sa_mode_e                        mode;
  logic signed [MUL_DATAWIDTH-1:0] bank_rd [WEIGHT_DEPTH];
  logic signed [MUL_DATAWIDTH-1:0] rd_weight;
  logic signed [ADD_DATAWIDTH-1:0] mac_psum;
  logic                            mac_ovf;

  logic                            weight_valid_reg;
  logic signed [MUL_DATAWIDTH-1:0] weight_reg;
  logic        [IDX_W-1:0]         weight_idx_reg;
  logic                            act_valid_reg;
  logic signed [MUL_DATAWIDTH-1:0] act_reg;
  logic        [IDX_W-1:0]         wsel_reg;
  logic                            psum_valid_reg;
  logic signed [ADD_DATAWIDTH-1:0] psum_reg;
  logic                            ovf_reg;

  assign mode = sa_mode_e'(bus.i_mode);

  // Register-based bank so reset can clear every entry asynchronously.
  genvar gi;
  generate
    for (gi = 0; gi < WEIGHT_DEPTH; gi++) begin : g_bank
      logic signed [MUL_DATAWIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          entry_reg <= '0;
        else if (mode == SA_PRELOAD && bus.i_weight_valid && bus.i_weight_idx == IDX_W'(gi))
          entry_reg <= bus.i_weight;
      end
      assign bank_rd[gi] = entry_reg;
    end
  endgenerate

  // Out-of-range selects match no entry and read as a zero weight.
  always_comb begin
    rd_weight = '0;
    for (int k = 0; k < WEIGHT_DEPTH; k++)
      if (bus.i_wsel == IDX_W'(k))
        rd_weight = bank_rd[k];
  end

  sa_mac_sat #(
    .MUL_DATAWIDTH(MUL_DATAWIDTH),
    .ADD_DATAWIDTH(ADD_DATAWIDTH),
    .SATURATE     (SATURATE)
  ) u_mac (
    .i_act   (bus.i_act),
    .i_weight(rd_weight),
    .i_psum  (bus.i_psum),
    .o_psum  (mac_psum),
    .o_ovf   (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_valid_reg <= 1'b0;
      weight_reg       <= '0;
      weight_idx_reg   <= '0;
      act_valid_reg    <= 1'b0;
      act_reg          <= '0;
      wsel_reg         <= '0;
      psum_valid_reg   <= 1'b0;
      psum_reg         <= '0;
      ovf_reg          <= 1'b0;
    end else begin
      if (mode == SA_PRELOAD) begin
        weight_valid_reg <= bus.i_weight_valid;
        weight_reg       <= bus.i_weight;
        weight_idx_reg   <= bus.i_weight_idx;
        act_valid_reg    <= 1'b0;
        psum_valid_reg   <= 1'b0;
      end else begin
        weight_valid_reg <= 1'b0;
        act_valid_reg    <= bus.i_act_valid;
        psum_valid_reg   <= bus.i_act_valid;
        if (bus.i_act_valid) begin
          act_reg  <= bus.i_act;
          wsel_reg <= bus.i_wsel;
          psum_reg <= mac_psum;
        end
      end
      // Clear wins over a same-cycle overflow.
      if (bus.i_clr_ovf)
        ovf_reg <= 1'b0;
      else if (mode == SA_COMPUTE && bus.i_act_valid && mac_ovf)
        ovf_reg <= 1'b1;
    end
  end

  assign bus.o_weight_valid = weight_valid_reg;
  assign bus.o_weight       = weight_reg;
  assign bus.o_weight_idx   = weight_idx_reg;
  assign bus.o_act_valid    = act_valid_reg;
  assign bus.o_act          = act_reg;
  assign bus.o_wsel         = wsel_reg;
  assign bus.o_psum_valid   = psum_valid_reg;
  assign bus.o_psum         = psum_reg;
  assign bus.o_ovf          = ovf_reg;
endmodule

// File: tb/tb_sa_pe_mw.sv
// Directed bench for sa_pe_mw across default, 16-bit saturating/wrapping and 3-deep configurations.
module tb_sa_pe_mw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  sa_pe_mw_if #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .WEIGHT_DEPTH(4)) bus_a ();
  sa_pe_mw_if #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(16), .WEIGHT_DEPTH(4)) bus_s ();
  sa_pe_mw_if #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(16), .WEIGHT_DEPTH(4)) bus_w ();
  sa_pe_mw_if #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .WEIGHT_DEPTH(3)) bus_r ();

  sa_pe_mw #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .WEIGHT_DEPTH(4), .SATURATE(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sa_pe_mw #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(16), .WEIGHT_DEPTH(4), .SATURATE(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  sa_pe_mw #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(16), .WEIGHT_DEPTH(4), .SATURATE(0))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  sa_pe_mw #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .WEIGHT_DEPTH(3), .SATURATE(1))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  // The wrapping instance sees exactly the saturating instance's stimulus.
  assign bus_w.i_mode         = bus_s.i_mode;
  assign bus_w.i_weight_valid = bus_s.i_weight_valid;
  assign bus_w.i_weight       = bus_s.i_weight;
  assign bus_w.i_weight_idx   = bus_s.i_weight_idx;
  assign bus_w.i_act_valid    = bus_s.i_act_valid;
  assign bus_w.i_act          = bus_s.i_act;
  assign bus_w.i_wsel         = bus_s.i_wsel;
  assign bus_w.i_psum         = bus_s.i_psum;
  assign bus_w.i_clr_ovf      = bus_s.i_clr_ovf;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %-18s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %-18s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [7:0]  w_tab [4];
    logic signed [31:0] exp_tab [4];
    w_tab   = '{8'sd1, -8'sd2, 8'sd3, 8'sd4};
    exp_tab = '{32'sd110, 32'sd80, 32'sd130, 32'sd140};

    bus_a.i_mode = 1'b0; bus_a.i_weight_valid = 1'b0; bus_a.i_weight = '0; bus_a.i_weight_idx = '0;
    bus_a.i_act_valid = 1'b0; bus_a.i_act = '0; bus_a.i_wsel = '0; bus_a.i_psum = '0; bus_a.i_clr_ovf = 1'b0;
    bus_s.i_mode = 1'b0; bus_s.i_weight_valid = 1'b0; bus_s.i_weight = '0; bus_s.i_weight_idx = '0;
    bus_s.i_act_valid = 1'b0; bus_s.i_act = '0; bus_s.i_wsel = '0; bus_s.i_psum = '0; bus_s.i_clr_ovf = 1'b0;
    bus_r.i_mode = 1'b0; bus_r.i_weight_valid = 1'b0; bus_r.i_weight = '0; bus_r.i_weight_idx = '0;
    bus_r.i_act_valid = 1'b0; bus_r.i_act = '0; bus_r.i_wsel = '0; bus_r.i_psum = '0; bus_r.i_clr_ovf = 1'b0;

    #12;
    check_eq("rst o_psum", bus_a.o_psum, 0);
    check_eq("rst o_weight_valid", bus_a.o_weight_valid, 0);
    check_eq("rst o_act_valid", bus_a.o_act_valid, 0);
    check_eq("rst o_ovf", bus_a.o_ovf, 0);
    rst_n = 1'b1;

    // Reset in the middle of preload
    bus_a.i_weight_valid = 1'b1; bus_a.i_weight = 8'sd5; bus_a.i_weight_idx = 2'd2;
    tick();
    check_eq("pre o_weight", bus_a.o_weight, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async o_weight", bus_a.o_weight, 0);
    check_eq("async o_wvalid", bus_a.o_weight_valid, 0);
    #1 rst_n = 1'b1;
    bus_a.i_weight_valid = 1'b0;
    bus_a.i_mode = 1'b1; bus_a.i_act_valid = 1'b1; bus_a.i_act = 8'sd3; bus_a.i_wsel = 2'd2; bus_a.i_psum = 32'sd7;
    tick();
    check_eq("postrst o_psum", bus_a.o_psum, 7);
    check_eq("postrst o_pvalid", bus_a.o_psum_valid, 1);

    // Weight forwarding, valid and invalid
    bus_a.i_mode = 1'b0; bus_a.i_act_valid = 1'b0;
    bus_a.i_weight_valid = 1'b1; bus_a.i_weight = -8'sd7; bus_a.i_weight_idx = 2'd1;
    tick();
    check_eq("fwd o_weight", bus_a.o_weight, -7);
    check_eq("fwd o_weight_idx", bus_a.o_weight_idx, 1);
    check_eq("fwd o_weight_valid", bus_a.o_weight_valid, 1);
    check_eq("fwd o_psum_valid", bus_a.o_psum_valid, 0);
    bus_a.i_weight_valid = 1'b0; bus_a.i_weight = 8'sd9;
    tick();
    check_eq("inv o_weight", bus_a.o_weight, 9);
    check_eq("inv o_weight_valid", bus_a.o_weight_valid, 0);
    bus_a.i_mode = 1'b1; bus_a.i_act_valid = 1'b1; bus_a.i_act = 8'sd1; bus_a.i_wsel = 2'd1; bus_a.i_psum = 32'sd0;
    tick();
    check_eq("bank1 o_psum", bus_a.o_psum, -7);

    // Multi-weight compute straight after preload; weight_valid during compute must not write
    bus_a.i_mode = 1'b0; bus_a.i_act_valid = 1'b0; bus_a.i_weight_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_a.i_weight = w_tab[k]; bus_a.i_weight_idx = 2'(k);
      tick();
    end
    bus_a.i_mode = 1'b1; bus_a.i_weight = 8'sd99; bus_a.i_weight_idx = 2'd0;
    bus_a.i_act_valid = 1'b1; bus_a.i_act = 8'sd10; bus_a.i_psum = 32'sd100;
    for (int k = 0; k < 4; k++) begin
      bus_a.i_wsel = 2'(k);
      tick();
      check_eq($sformatf("mw o_psum[%0d]", k), bus_a.o_psum, exp_tab[k]);
      check_eq($sformatf("mw o_pvalid[%0d]", k), bus_a.o_psum_valid, 1);
    end
    check_eq("cmp o_weight_valid", bus_a.o_weight_valid, 0);
    bus_a.i_wsel = 2'd0;
    tick();
    check_eq("ro bank0 o_psum", bus_a.o_psum, 110);
    bus_a.i_weight_valid = 1'b0;

    // Bubbles, then drop to preload with a valid activation in flight
    bus_a.i_act = 8'sd2; bus_a.i_wsel = 2'd0; bus_a.i_psum = 32'sd5;
    tick();
    check_eq("b1 o_psum", bus_a.o_psum, 7);
    bus_a.i_act_valid = 1'b0; bus_a.i_act = 8'sd99; bus_a.i_wsel = 2'd2; bus_a.i_psum = 32'sd1000;
    tick();
    check_eq("b0 o_psum_valid", bus_a.o_psum_valid, 0);
    check_eq("b0 o_psum hold", bus_a.o_psum, 7);
    check_eq("b0 o_act hold", bus_a.o_act, 2);
    bus_a.i_act_valid = 1'b1; bus_a.i_act = -8'sd3; bus_a.i_wsel = 2'd3; bus_a.i_psum = 32'sd0;
    tick();
    check_eq("b2 o_psum", bus_a.o_psum, -12);
    check_eq("b2 o_psum_valid", bus_a.o_psum_valid, 1);
    bus_a.i_mode = 1'b0; bus_a.i_act = 8'sd50; bus_a.i_psum = 32'sd50;
    tick();
    check_eq("flip o_act_valid", bus_a.o_act_valid, 0);
    check_eq("flip o_psum_valid", bus_a.o_psum_valid, 0);
    check_eq("flip o_psum hold", bus_a.o_psum, -12);
    check_eq("flip o_act hold", bus_a.o_act, -3);

    // 16-bit saturate vs wrap
    bus_s.i_weight_valid = 1'b1; bus_s.i_weight = 8'sd127; bus_s.i_weight_idx = 2'd0;
    tick();
    bus_s.i_mode = 1'b1; bus_s.i_weight_valid = 1'b0;
    bus_s.i_act_valid = 1'b1; bus_s.i_act = 8'sd127; bus_s.i_wsel = 2'd0; bus_s.i_psum = 16'sd32000;
    tick();
    check_eq("sat o_psum", bus_s.o_psum, 32767);
    check_eq("sat o_ovf", bus_s.o_ovf, 1);
    check_eq("wrap o_psum", bus_w.o_psum, -17407);
    check_eq("wrap o_ovf", bus_w.o_ovf, 1);
    bus_s.i_clr_ovf = 1'b1;
    tick();
    check_eq("clr sat o_ovf", bus_s.o_ovf, 0);
    check_eq("clr wrap o_ovf", bus_w.o_ovf, 0);
    check_eq("clr sat o_psum", bus_s.o_psum, 32767);
    bus_s.i_clr_ovf = 1'b0; bus_s.i_act = 8'sd1; bus_s.i_psum = 16'sd0;
    tick();
    check_eq("nov o_psum", bus_s.o_psum, 127);
    check_eq("nov o_ovf", bus_s.o_ovf, 0);
    bus_s.i_act = -8'sd128; bus_s.i_psum = -16'sd32000;
    tick();
    check_eq("neg sat o_psum", bus_s.o_psum, -32768);
    check_eq("neg wrap o_psum", bus_w.o_psum, 17280);
    check_eq("neg sat o_ovf", bus_s.o_ovf, 1);
    bus_s.i_act = 8'sd1; bus_s.i_psum = 16'sd5;
    tick();
    check_eq("sticky o_psum", bus_s.o_psum, 132);
    check_eq("sticky o_ovf", bus_s.o_ovf, 1);

    // Out-of-range slot index on a 3-deep bank
    bus_r.i_weight_valid = 1'b1; bus_r.i_weight = 8'sd6; bus_r.i_weight_idx = 2'd0;
    tick();
    bus_r.i_weight = 8'sd11; bus_r.i_weight_idx = 2'd3;
    tick();
    check_eq("oor o_weight", bus_r.o_weight, 11);
    check_eq("oor o_weight_idx", bus_r.o_weight_idx, 3);
    check_eq("oor o_weight_valid", bus_r.o_weight_valid, 1);
    bus_r.i_mode = 1'b1; bus_r.i_weight_valid = 1'b0;
    bus_r.i_act_valid = 1'b1; bus_r.i_act = 8'sd5; bus_r.i_wsel = 2'd3; bus_r.i_psum = -32'sd9;
    tick();
    check_eq("oor wsel o_psum", bus_r.o_psum, -9);
    bus_r.i_act = 8'sd2; bus_r.i_wsel = 2'd0; bus_r.i_psum = 32'sd1;
    tick();
    check_eq("oor bank0 o_psum", bus_r.o_psum, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
